// File: rtl/ma_xif_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ma_xif_sequencer
// Description : CV-X-IF coprocessor-side queue, commit tracker and in-order
//               dispatcher for the matrix accelerator datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module ma_xif_sequencer #(
    parameter int          XLEN     = 32,
    parameter int          ID_WIDTH = 4,
    parameter int          DEPTH    = 4,
    parameter logic [6:0]  OPCODE   = 7'h0B
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [31:0]         issue_instr_i,
    input  logic [ID_WIDTH-1:0] issue_id_i,
    input  logic [XLEN-1:0]     issue_rs1_i,
    input  logic [XLEN-1:0]     issue_rs2_i,
    output logic                issue_accept_o,
    output logic                issue_writeback_o,
    input  logic                commit_valid_i,
    input  logic [ID_WIDTH-1:0] commit_id_i,
    input  logic                commit_kill_i,
    output logic                ma_req_valid_o,
    input  logic                ma_req_ready_i,
    output logic [31:0]         ma_req_instr_o,
    output logic [XLEN-1:0]     ma_req_rs1_o,
    output logic [XLEN-1:0]     ma_req_rs2_o,
    input  logic                ma_done_i,
    input  logic [XLEN-1:0]     ma_rdata_i,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [ID_WIDTH-1:0] result_id_o,
    output logic [XLEN-1:0]     result_data_o,
    output logic                result_we_o,
    output logic                busy_o
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ENT_EMPTY  = 2'd0,
        ENT_PEND   = 2'd1,
        ENT_COMMIT = 2'd2,
        ENT_KILL   = 2'd3
    } entry_st_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        EXEC     = 2'd2,
        RESP     = 2'd3
    } state_t;

    logic [31:0]         r_instr_q [DEPTH];
    logic [ID_WIDTH-1:0] r_id_q    [DEPTH];
    logic [XLEN-1:0]     r_rs1_q   [DEPTH];
    logic [XLEN-1:0]     r_rs2_q   [DEPTH];
    logic                r_we_q    [DEPTH];
    entry_st_t           r_st_q    [DEPTH];

    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    state_t          r_state;
    state_t          w_state_d;
    logic [XLEN-1:0] r_result_data;

    logic      w_enq;
    logic      w_pop;
    logic      w_capture;
    entry_st_t w_enq_st;
    entry_st_t w_head_st;

    // ------------------------------------------------------------------
    // Issue interface
    // ------------------------------------------------------------------
    assign issue_accept_o    = (issue_instr_i[6:0] == OPCODE);
    assign issue_writeback_o = issue_accept_o & issue_instr_i[14] & (issue_instr_i[11:7] != 5'd0);
    // Held low during reset so the core never sees a ready queue while flushing.
    assign issue_ready_o     = rst_ni & (r_count != FULL_COUNT);
    assign w_enq             = issue_valid_i & issue_ready_o & issue_accept_o;

    // A commit arriving together with its own enqueue resolves the new entry.
    always_comb begin
        w_enq_st = ENT_PEND;
        if (commit_valid_i && (commit_id_i == issue_id_i)) begin
            w_enq_st = commit_kill_i ? ENT_KILL : ENT_COMMIT;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_instr_q[r_wr_ptr] <= issue_instr_i;
            r_id_q[r_wr_ptr]    <= issue_id_i;
            r_rs1_q[r_wr_ptr]   <= issue_rs1_i;
            r_rs2_q[r_wr_ptr]   <= issue_rs2_i;
            r_we_q[r_wr_ptr]    <= issue_writeback_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_st_q[i] <= ENT_EMPTY;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_pop && (r_rd_ptr == AW'(i))) begin
                    r_st_q[i] <= ENT_EMPTY;
                end else if (w_enq && (r_wr_ptr == AW'(i))) begin
                    r_st_q[i] <= w_enq_st;
                end else if (commit_valid_i && (r_st_q[i] == ENT_PEND) &&
                             (r_id_q[i] == commit_id_i)) begin
                    r_st_q[i] <= commit_kill_i ? ENT_KILL : ENT_COMMIT;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_enq, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Head-of-queue sequencer
    // ------------------------------------------------------------------
    assign w_head_st = r_st_q[r_rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= IDLE;
            r_result_data <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_capture) r_result_data <= ma_rdata_i;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_pop     = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_head_st == ENT_KILL) begin
                    w_pop = 1'b1;
                end else if (w_head_st == ENT_COMMIT) begin
                    w_state_d = DISPATCH;
                end
            end
            DISPATCH: begin
                if (ma_req_ready_i) w_state_d = EXEC;
            end
            EXEC: begin
                if (ma_done_i) begin
                    w_capture = 1'b1;
                    w_state_d = RESP;
                end
            end
            RESP: begin
                if (result_ready_i) begin
                    w_pop     = 1'b1;
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    // Payloads are gated by state so every output reads zero outside its phase.
    assign ma_req_valid_o = (r_state == DISPATCH);
    assign ma_req_instr_o = ma_req_valid_o ? r_instr_q[r_rd_ptr] : '0;
    assign ma_req_rs1_o   = ma_req_valid_o ? r_rs1_q[r_rd_ptr]   : '0;
    assign ma_req_rs2_o   = ma_req_valid_o ? r_rs2_q[r_rd_ptr]   : '0;

    assign result_valid_o = (r_state == RESP);
    assign result_id_o    = result_valid_o ? r_id_q[r_rd_ptr] : '0;
    assign result_we_o    = result_valid_o & r_we_q[r_rd_ptr];
    assign result_data_o  = result_valid_o ? r_result_data : '0;

    assign busy_o = (r_count != '0) | (r_state != IDLE);

endmodule
`default_nettype wire
